// File: rtl/rng_pkg.sv
// Shared types and constants for the pseudo-random request source.
// Holds the FSM state enum, default Galois taps per width, default seed.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    OFFER = 2'd2
  } req_state_t;

  localparam logic [31:0] DEF_SEED = 32'h0000_0001;

  // Right-shifting Galois masks, maximal-length for each width.
  function automatic logic [31:0] default_taps(input int unsigned w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0E08;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with enable and synchronous seed reload (0 -> SEED).
// Ports: clk, rst (async low), en, seed_load, seed in; q = state out.
module lfsr_galois #(
  parameter int unsigned      WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS  = 12'hE08,
  parameter logic [WIDTH-1:0] SEED  = 12'h001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q >> 1;
    if (q[0]) nxt = nxt ^ TAPS;
  end

  // A zero seed would lock the register, so it falls back to SEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (seed_load) begin
      q <= (seed == '0) ? SEED : seed;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/request_gen.sv
// Pseudo-random elevator request source: LFSR draws, range filter, valid/ready.
// Ports: clk, rst, en, mode, seed_load, seed in; req_* handshake; randy raw LFSR.
module request_gen
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH      = 12,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEF_SEED),
  parameter int unsigned      NUM_FLOORS = 8,
  parameter int unsigned      INTERVAL   = 16,
  localparam int unsigned     FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [FLOOR_W-1:0] req_floor,
  output logic               req_dir,
  output logic [WIDTH-1:0]   randy
);

  localparam int unsigned CNT_W = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(INTERVAL - 1);
  localparam logic [FLOOR_W:0] NF =
    (FLOOR_W + 1)'(NUM_FLOORS);

  logic [WIDTH-1:0]   lfsr;
  logic [CNT_W-1:0]   cnt;
  logic [FLOOR_W-1:0] cand;
  logic               cand_ok;
  logic               hs;
  logic               pend;
  req_state_t         state;

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .q         (lfsr)
  );

  assign randy   = lfsr;
  assign cand    = lfsr[FLOOR_W-1:0];
  assign cand_ok = {1'b0, cand} < NF;
  assign hs      = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (hs) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // pend: handshake taken while frozen; the
  // exit from OFFER waits for the next enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_floor <= '0;
      req_dir   <= 1'b0;
      pend      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && (mode || cnt == LAST))
            state <= DRAW;
        end
        DRAW: begin
          if (en && cand_ok) begin
            req_floor <= cand;
            req_dir   <= lfsr[WIDTH-1];
            req_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            req_valid <= 1'b0;
            if (en) state <= mode ? DRAW : IDLE;
            else    pend  <= 1'b1;
          end else if (pend && en) begin
            pend  <= 1'b0;
            state <= mode ? DRAW : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_request_gen.sv
// Self-checking bench for request_gen: two instances (8 and 5 floors).
// Random ready, reference model built from event times, not RTL states.
module tb_request_gen;

  localparam int          INTV = 16;
  localparam logic [11:0] TP   = 12'hE08;
  localparam logic [11:0] SD   = 12'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        seed_load = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] seed = '0;

  logic        v0, v5, d0, d5;
  logic [2:0]  f0, f5;
  logic [11:0] r0, r5;

  int total = 0;
  int bad   = 0;

  int          n = 0;
  logic [11:0] m = SD;
  int          nf [2] = '{8, 5};
  bit          offer [2];
  int          tedge [2];
  int          ef [2];
  bit          ed [2];

  logic [11:0] known [0:5] =
    '{12'h001, 12'hE08, 12'h704, 12'h382, 12'h1C1, 12'hEE8};

  always #5 clk = ~clk;

  request_gen dut0 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .seed_load (seed_load),
    .seed      (seed),
    .req_valid (v0),
    .req_ready (ready),
    .req_floor (f0),
    .req_dir   (d0),
    .randy     (r0)
  );

  request_gen #(.NUM_FLOORS(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .seed_load (seed_load),
    .seed      (seed),
    .req_valid (v5),
    .req_ready (ready),
    .req_floor (f5),
    .req_dir   (d5),
    .randy     (r5)
  );

  function automatic logic [11:0] nxt(input logic [11:0] x);
    return (x >> 1) ^ (x[0] ? TP : 12'h000);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("randy0", 32'(r0), 32'(m));
    chk("randy5", 32'(r5), 32'(m));
    chk("valid0", 32'(v0), 32'(offer[0]));
    chk("valid5", 32'(v5), 32'(offer[1]));
    if (offer[0]) begin
      chk("floor0", 32'(f0), 32'(ef[0]));
      chk("dir0", 32'(d0), 32'(ed[0]));
    end
    if (offer[1]) begin
      chk("floor5", 32'(f5), 32'(ef[1]));
      chk("dir5", 32'(d5), 32'(ed[1]));
      chk("range5", 32'(f5 < 3'd5), 32'd1);
    end
  endtask

  // One rising edge; update the model from the inputs that were applied.
  task automatic tick();
    logic [11:0] mb;
    mb = m;
    @(posedge clk);
    #1;
    if (en) n++;
    if (seed_load) m = (seed == 12'h000) ? SD : seed;
    else if (en) m = nxt(m);
    for (int d = 0; d < 2; d++) begin
      if (offer[d]) begin
        if (ready) begin
          offer[d] = 1'b0;
          tedge[d] = mode ? n + 1 : n + INTV + 1;
        end
      end else if (en) begin
        if (n < tedge[d]) begin
          if (mode) tedge[d] = n + 1;
        end else if (int'(mb[2:0]) < nf[d]) begin
          offer[d] = 1'b1;
          ef[d]    = int'(mb[2:0]);
          ed[d]    = mb[11];
        end
      end
    end
    check_all();
  endtask

  initial begin
    logic [2:0]  hf;
    logic        hd;
    logic [11:0] prev;
    int          k;

    offer = '{1'b0, 1'b0};
    tedge = '{INTV + 1, INTV + 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_randy0", 32'(r0), 32'(SD));
    chk("rst_randy5", 32'(r5), 32'(SD));
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_valid5", 32'(v5), 32'd0);
    chk("rst_floor0", 32'(f0), 32'd0);
    chk("rst_dir0", 32'(d0), 32'd0);
    chk("rst_floor5", 32'(f5), 32'd0);
    chk("rst_dir5", 32'(d5), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    mode = 1'b0;
    ready = 1'b1;

    for (int i = 1; i < 6; i++) begin
      tick();
      chk("seq", 32'(r0), 32'(known[i]));
    end
    while (n < 60) tick();

    while (n < 4095) begin
      ready = ($urandom_range(0, 3) != 0);
      tick();
      chk("nonzero", 32'(r0 != 12'h000), 32'd1);
    end
    chk("period", 32'(r0), 32'(SD));

    ready = 1'b0;
    k = 0;
    while (!v0 && k < 200) begin
      tick();
      k++;
    end
    chk("offer_seen", 32'(v0), 32'd1);
    hf = f0;
    hd = d0;
    prev = r0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_f", 32'(f0), 32'(hf));
      chk("hold_d", 32'(d0), 32'(hd));
      chk("moves", 32'(r0 != prev), 32'd1);
      prev = r0;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frozen", 32'(r0), 32'(prev));
      chk("hold_v", 32'(v0), 32'd1);
    end
    en = 1'b1;
    seed = 12'h000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("reload", 32'(r0), 32'h001);
    chk("reload_f", 32'(f0), 32'(hf));
    chk("reload_v", 32'(v0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_f", 32'(f0), 32'(hf));
    ready = 1'b1;
    tick();
    chk("drop", 32'(v0), 32'd0);

    mode = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < 60; i++) begin
      ready = $urandom_range(0, 1) != 0;
      tick();
    end

    ready = 1'b0;
    k = 0;
    while (!v0 && k < 50) begin
      tick();
      k++;
    end
    chk("cont_offer", 32'(v0), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_v0", 32'(v0), 32'd0);
    chk("async_v5", 32'(v5), 32'd0);
    chk("async_randy", 32'(r0), 32'(SD));
    @(posedge clk);
    #1;
    chk("held_rst", 32'(v0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
